eq2_sweep_driver: RTL and testbench



---
 rtl/eq2_sweep_driver.sv | 138 +++++++++++++
 tb/tb_eq2_sweep_driver.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq2_sweep_driver.sv
// -----------------------------------------------------------------------------
// eq2_sweep_driver
//
// Synthesizable self-test for a W-bit equality comparator. On start it drives
// every (a,b) operand pair in ascending order. It waits SETTLE cycles for the
// comparator to respond, then samples ledpin_in. It checks the sample against
// a==b and accumulates match/fail counts.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   level; launches a sweep when sampled in IDLE
//   a_out      out  [W-1:0]      operand A to comparator (registered)
//   b_out      out  [W-1:0]      operand B to comparator (registered)
//   ledpin_in  in   comparator result, synchronous to clk
//   busy       out  high whenever the FSM is not in IDLE
//   done       out  one-cycle pulse at the end of a sweep
//   match_cnt  out  [CNT_W-1:0]  vectors sampled with ledpin_in=1
//   fail_cnt   out  [CNT_W-1:0]  vectors where ledpin_in != (a_out==b_out)
//   err        out  sticky failure flag for the current sweep
// -----------------------------------------------------------------------------
module eq2_sweep_driver #(
    parameter int W      = 2,
    parameter int SETTLE = 2,         // 1..15
    parameter int CNT_W  = 2 * W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [W-1:0]     a_out,
    output logic [W-1:0]     b_out,
    input  logic             ledpin_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err
);

    localparam int              IDX_W     = 2 * W;
    localparam logic [IDX_W-1:0] IDX_LAST = '1;
    localparam logic [3:0]      SETTLE_LD = 4'(SETTLE - 1);

    // Bit 2 is set in every state except IDLE. busy is therefore a single
    // flop output and cannot glitch when the FSM moves between busy states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_DRIVE  = 3'b100,
        S_WAIT   = 3'b101,
        S_SAMPLE = 3'b111,
        S_DONE   = 3'b110
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [3:0]       settle_cnt;
    logic             exp_eq;

    // The operands are slices of the registered index. They change only on
    // the clock edge that advances idx.
    assign a_out  = idx[IDX_W-1:W];
    assign b_out  = idx[W-1:0];
    assign exp_eq = (a_out == b_out);
    assign busy   = state[2];

    // NOTE: the reset is in the sensitivity list, so it takes effect
    // immediately without waiting for a clock. It still must be deasserted
    // cleanly relative to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            done       <= 1'b0;
            match_cnt  <= '0;
            fail_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere in clocked logic.
            // Every right-hand side then sees pre-edge values. The default
            // below is overridden later in this block when DONE is entered.
            done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_DRIVE;
                        idx       <= '0;
                        match_cnt <= '0;
                        fail_cnt  <= '0;
                        err       <= 1'b0;
                    end
                end

                S_DRIVE: begin
                    settle_cnt <= SETTLE_LD;
                    state      <= S_WAIT;
                end

                // The counter is loaded with SETTLE-1 and exits on zero.
                // This gives exactly SETTLE cycles in WAIT.
                S_WAIT: begin
                    if (settle_cnt == 4'd0) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                S_SAMPLE: begin
                    if (ledpin_in) begin
                        match_cnt <= match_cnt + CNT_W'(1);
                    end
                    if (ledpin_in != exp_eq) begin
                        fail_cnt <= fail_cnt + CNT_W'(1);
                        err      <= 1'b1;
                    end
                    if (idx == IDX_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= S_DRIVE;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq2_sweep_driver.sv
// -----------------------------------------------------------------------------
// tb_eq2_sweep_driver
//
// Three instances of the sweep driver share one clock and one reset:
//   u2 (SETTLE=2) is fed by a per-vector lookup table with random noise
//   outside its sample cycle.
//   u1 (SETTLE=1) and u4 (SETTLE=4) each see a comparator whose output lags
//   its operands by three cycles.
// -----------------------------------------------------------------------------
module tb_eq2_sweep_driver;

    localparam int W     = 2;
    localparam int CNT_W = 2 * W + 1;
    localparam int N     = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- u2: SETTLE=2, table-driven ledpin ----------------
    logic             start2, ledpin2, busy2, done2, err2;
    logic [W-1:0]     a2, b2;
    logic [CNT_W-1:0] match2, fail2;

    eq2_sweep_driver #(.W(W), .SETTLE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2),
        .ledpin_in(ledpin2), .busy(busy2), .done(done2),
        .match_cnt(match2), .fail_cnt(fail2), .err(err2)
    );

    // ---------------- u1 / u4: comparator with 3-cycle output lag --------------
    logic             start1, led1, busy1, done1, err1;
    logic [W-1:0]     a1, b1;
    logic [CNT_W-1:0] match1, fail1;
    logic [2:0]       pipe1;

    logic             start4, led4, busy4, done4, err4;
    logic [W-1:0]     a4, b4;
    logic [CNT_W-1:0] match4, fail4;
    logic [2:0]       pipe4;

    eq2_sweep_driver #(.W(W), .SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1),
        .ledpin_in(led1), .busy(busy1), .done(done1),
        .match_cnt(match1), .fail_cnt(fail1), .err(err1)
    );

    eq2_sweep_driver #(.W(W), .SETTLE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a_out(a4), .b_out(b4),
        .ledpin_in(led4), .busy(busy4), .done(done4),
        .match_cnt(match4), .fail_cnt(fail4), .err(err4)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe1 <= 3'b111;
            pipe4 <= 3'b111;
        end else begin
            pipe1 <= {pipe1[1:0], a1 == b1};
            pipe4 <= {pipe4[1:0], a4 == b4};
        end
    end
    assign led1 = pipe1[2];
    assign led4 = pipe4[2];

    // ---------------- reference model ----------------
    bit lut[N];   // ledpin value presented during the SAMPLE cycle of each vector

    function automatic bit eqf(input int k);
        return ((k >> 2) & 3) == (k & 3);
    endfunction

    // Counts after the first k_done vectors have been sampled.
    task automatic model_counts(input int k_done, output int m, output int f);
        m = 0;
        f = 0;
        for (int k = 0; k < k_done; k++) begin
            if (lut[k]) m++;
            if (lut[k] != eqf(k)) f++;
        end
    endtask

    // One full u2 sweep. c counts edges after the edge that accepted start.
    // Vector k owns edges 4k..4k+3, and its sample is taken at edge 4k+4.
    task automatic sweep2(input bit noisy_start, input string tag);
        int k_done, m, f, idx;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int c = 0; c <= 65; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            k_done = (c / 4 > N) ? N : c / 4;
            idx    = (c / 4 > N - 1) ? N - 1 : c / 4;
            model_counts(k_done, m, f);
            check({tag, " a"}, 32'(a2), 32'(idx >> 2));
            check({tag, " b"}, 32'(b2), 32'(idx & 3));
            check({tag, " done"}, 32'(done2), 32'(c == 64));
            check({tag, " busy"}, 32'(busy2), 32'(c <= 64));
            check({tag, " match"}, 32'(match2), 32'(m));
            check({tag, " fail"}, 32'(fail2), 32'(f));
            check({tag, " err"}, 32'(err2), 32'(f > 0));
            // A clean value is driven in the SAMPLE cycle only; noise elsewhere.
            ledpin2 = (c % 4 == 3 && c < 64) ? lut[idx] : 1'($urandom);
            start2  = (noisy_start && c <= 64) ? 1'($urandom) : 1'b0;
        end
    endtask

    int  m_exp, f_exp, c, done_cnt;
    bit  seen;

    initial begin
        rst_n  = 1'b0;
        start2 = 1'b0;
        start1 = 1'b0;
        start4 = 1'b0;
        ledpin2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst a", 32'(a2), 0);
        check("rst b", 32'(b2), 0);
        check("rst busy", 32'(busy2), 0);
        check("rst done", 32'(done2), 0);
        check("rst match", 32'(match2), 0);
        check("rst fail", 32'(fail2), 0);
        check("rst err", 32'(err2), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle without start: nothing happens.
        repeat (3) @(posedge clk);
        #1;
        check("idle busy", 32'(busy2), 0);

        // Correct comparator.
        for (int k = 0; k < N; k++) lut[k] = eqf(k);
        sweep2(1'b0, "good");
        // Stuck at 0.
        for (int k = 0; k < N; k++) lut[k] = 1'b0;
        sweep2(1'b0, "stuck0");
        check("stuck0 final fail", 32'(fail2), 4);
        // Stuck at 1.
        for (int k = 0; k < N; k++) lut[k] = 1'b1;
        sweep2(1'b0, "stuck1");
        check("stuck1 final match", 32'(match2), 16);
        check("stuck1 final fail", 32'(fail2), 12);
        // Random faulty comparators, with random start pulses during the sweep.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) lut[k] = 1'($urandom);
            sweep2(1'b1, "random");
        end
        // Idle with start low: counters keep the last sweep's values.
        model_counts(N, m_exp, f_exp);
        repeat (4) @(posedge clk);
        #1;
        check("hold match", 32'(match2), 32'(m_exp));
        check("hold fail", 32'(fail2), 32'(f_exp));

        // start held high: back-to-back sweeps 66 edges apart.
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        done_cnt = 0;
        for (int cc = 0; cc <= 265; cc++) begin
            if (cc > 0) begin
                @(posedge clk);
                #1;
            end
            ledpin2 = (a2 == b2);
            if (done2) done_cnt++;
            check("b2b done", 32'(done2), 32'(cc % 66 == 64));
            if (cc % 66 == 0 && cc <= 198) begin
                check("b2b clear match", 32'(match2), 0);
                check("b2b clear fail", 32'(fail2), 0);
            end
            if (cc % 66 == 64) begin
                check("b2b match", 32'(match2), 4);
                check("b2b fail", 32'(fail2), 0);
            end
            if (cc == 200) start2 = 1'b0;
        end
        check("b2b done count", 32'(done_cnt), 4);

        // Reset during WAIT of vector 2/1 (idx 9, edge 37).
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int cc = 1; cc <= 37; cc++) begin
            @(posedge clk);
            #1;
            ledpin2 = (a2 == b2);
        end
        check("pre-rst a", 32'(a2), 2);
        check("pre-rst b", 32'(b2), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst a", 32'(a2), 0);
        check("async rst b", 32'(b2), 0);
        check("async rst busy", 32'(busy2), 0);
        check("async rst match", 32'(match2), 0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done2) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done2 || busy2) seen = 1'b1;
        end
        check("rst no done/resume", 32'(seen), 0);
        for (int k = 0; k < N; k++) lut[k] = eqf(k);
        sweep2(1'b0, "post-rst");
        check("post-rst match", 32'(match2), 4);

        // 3-cycle-lag comparator, SETTLE=1: each sample sees the previous vector.
        f_exp = 0;
        for (int k = 0; k < N; k++) begin
            if (eqf(k) != ((k == 0) ? 1'b1 : eqf(k - 1))) f_exp++;
        end
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        c = 0;
        seen = 1'b0;
        while (!seen && c < 300) begin
            @(posedge clk);
            #1;
            c++;
            if (done1) seen = 1'b1;
        end
        check("lag s1 done edge", 32'(c), 48);
        check("lag s1 fail", 32'(fail1), 32'(f_exp));
        check("lag s1 fail nonzero", 32'(fail1 != 0), 1);
        check("lag s1 err", 32'(err1), 1);

        // Same comparator with SETTLE=4: the lag is covered.
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        c = 0;
        seen = 1'b0;
        while (!seen && c < 300) begin
            @(posedge clk);
            #1;
            c++;
            if (done4) seen = 1'b1;
        end
        check("lag s4 done edge", 32'(c), 96);
        check("lag s4 fail", 32'(fail4), 0);
        check("lag s4 match", 32'(match4), 4);
        check("lag s4 err", 32'(err4), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
